// File: rtl/demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer family.
//   state_e  : frame-alignment state (hunting for sync / locked to frame)
//   NChDef   : default number of time slots per frame
//   SelWDef  : default channel-index width, clog2(NChDef)
package demux_pkg;

  typedef enum logic {
    StHunt = 1'b0,
    StLock = 1'b1
  } state_e;

  localparam int unsigned NChDef  = 4;
  localparam int unsigned SelWDef = 2;

endpackage

// File: rtl/demux_tdm_sync_if.sv
// Bundle of the serial-in / parallel-out signals of demux_tdm_sync.
//   din, din_valid, sync : serial TDM beat from the link (source -> demux)
//   y, y_valid           : one-hot demux of the last accepted beat
//   ch_idx               : slot the next accepted beat lands in
//   dout, dout_valid     : reassembled frame, bit i = channel i
//   frame_err            : sync framing violation pulse
//   locked               : demux is aligned to the frame
// master = stream source / consumer side, slave = demux.
interface demux_tdm_sync_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = 2
);
  logic             din;
  logic             din_valid;
  logic             sync;
  logic [N_CH-1:0]  y;
  logic             y_valid;
  logic [SEL_W-1:0] ch_idx;
  logic [N_CH-1:0]  dout;
  logic             dout_valid;
  logic             frame_err;
  logic             locked;

  modport master (
    output din, din_valid, sync,
    input  y, y_valid, ch_idx, dout, dout_valid, frame_err, locked
  );

  modport slave (
    input  din, din_valid, sync,
    output y, y_valid, ch_idx, dout, dout_valid, frame_err, locked
  );
endinterface

// File: rtl/demux_onehot.sv
// Combinational N_CH-way 1-bit demux: routes i_din to bit i_ch of o_y, all
// other bits 0. Out-of-range indices (non-power-of-2 N_CH) give all zeros.
//   i_din : data bit
//   i_ch  : destination channel
//   o_y   : one-hot-placed data
module demux_onehot #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic             i_din,
  input  logic [SEL_W-1:0] i_ch,
  output logic [N_CH-1:0]  o_y
);

  always_comb begin
    o_y = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      o_y[i] = i_din & (i_ch == SEL_W'(i));
    end
  end

endmodule

// File: rtl/demux_tdm_sync.sv
// Receive-side TDM demultiplexer. Aligns to a sync-marked 1-bit stream,
// demuxes each beat to its channel and reassembles full frames into a
// parallel word.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : demux_tdm_sync_if.slave (serial input, demux/frame outputs)
module demux_tdm_sync
  import demux_pkg::*;
#(
  parameter int unsigned N_CH  = NChDef,
  parameter int unsigned SEL_W = SelWDef
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux_tdm_sync_if.slave        bus
);

  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] FirstData = SEL_W'(1);

  state_e           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ch, w_ch_nxt;
  // Channels 0..N_CH-2 are buffered; the last channel goes straight to dout.
  logic [N_CH-2:0]  r_slot, w_slot_nxt;
  logic [N_CH-1:0]  r_y, w_y_nxt;
  logic             r_y_valid, w_y_valid_nxt;
  logic [N_CH-1:0]  r_dout, w_dout_nxt;
  logic             r_dout_valid, w_dout_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;

  logic             w_demux;
  logic [SEL_W-1:0] w_dec_ch;
  logic [N_CH-1:0]  w_dec_y;

  // A sync beat always lands in channel 0, even if it arrives early.
  assign w_dec_ch = bus.sync ? '0 : r_ch;

  demux_onehot #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_onehot (
    .i_din (bus.din),
    .i_ch  (w_dec_ch),
    .o_y   (w_dec_y)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_ch_nxt         = r_ch;
    w_slot_nxt       = r_slot;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_demux          = 1'b0;

    if (bus.din_valid) begin
      case (r_state)
        StHunt: begin
          if (bus.sync) begin
            w_state_nxt   = StLock;
            w_slot_nxt[0] = bus.din;
            w_ch_nxt      = FirstData;
            w_demux       = 1'b1;
          end
        end
        StLock: begin
          if (bus.sync) begin
            // Early sync drops the partial frame and restarts at channel 0.
            w_frame_err_nxt = (r_ch != '0);
            w_slot_nxt[0]   = bus.din;
            w_ch_nxt        = FirstData;
            w_demux         = 1'b1;
          end else if (r_ch == '0) begin
            // Missing sync: lost alignment, beat is not demuxed.
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = StHunt;
            w_ch_nxt        = '0;
          end else if (r_ch == LastCh) begin
            w_dout_nxt       = {bus.din, r_slot};
            w_dout_valid_nxt = 1'b1;
            w_ch_nxt         = '0;
            w_demux          = 1'b1;
          end else begin
            for (int unsigned i = 1; i < N_CH - 1; i++) begin
              if (r_ch == SEL_W'(i)) begin
                w_slot_nxt[i] = bus.din;
              end
            end
            // Explicit compare above handles wrap, so no modulo reliance here.
            w_ch_nxt = r_ch + FirstData;
            w_demux  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = StHunt;
          w_ch_nxt    = '0;
        end
      endcase
    end

    w_y_nxt       = w_demux ? w_dec_y : r_y;
    w_y_valid_nxt = w_demux;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StHunt;
      r_ch         <= '0;
      r_slot       <= '0;
      r_y          <= '0;
      r_y_valid    <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ch         <= w_ch_nxt;
      r_slot       <= w_slot_nxt;
      r_y          <= w_y_nxt;
      r_y_valid    <= w_y_valid_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign bus.y          = r_y;
  assign bus.y_valid    = r_y_valid;
  assign bus.ch_idx     = r_ch;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.locked     = (r_state == StLock);

endmodule

// File: tb/tb_demux_tdm_sync.sv
module tb_demux_tdm_sync;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef struct {
    logic       rst_n;
    logic       dv;
    logic       sync;
    logic       din;
    logic [3:0] y;
    logic       yv;
    logic [1:0] ch;
    logic [3:0] dout;
    logic       dov;
    logic       fe;
    logic       lk;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  vec_t vecs[$];

  demux_tdm_sync_if #(.N_CH(N_CH), .SEL_W(SEL_W)) bus ();

  demux_tdm_sync #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic dv, input logic s, input logic d,
                     input logic [3:0] y, input logic yv, input logic [1:0] ch,
                     input logic [3:0] dout, input logic dov, input logic fe,
                     input logic lk);
    vec_t v;
    v.rst_n = r; v.dv = dv; v.sync = s; v.din = d;
    v.y = y; v.yv = yv; v.ch = ch; v.dout = dout; v.dov = dov; v.fe = fe; v.lk = lk;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs and sample outputs #1 after the rising edge.
  task automatic step(input logic r, input logic dv, input logic s, input logic d);
    rst_n         = r;
    bus.din_valid = dv;
    bus.sync      = s;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] frames [3];

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    bus.sync = 1'b0;
    #1;

    //  rst dv s  d   y      yv ch     dout   dov fe lk
    // Reset with active sync beats: nothing may happen.
    add(0, 1, 1, 1, 4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0);
    // Frame 0001 from HUNT.
    add(1, 1, 1, 1, 4'b0001, 1, 2'd1, 4'b0000, 0, 0, 1);
    add(1, 1, 0, 0, 4'b0000, 1, 2'd2, 4'b0000, 0, 0, 1);
    add(1, 1, 0, 0, 4'b0000, 1, 2'd3, 4'b0000, 0, 0, 1);
    add(1, 1, 0, 0, 4'b0000, 1, 2'd0, 4'b0001, 1, 0, 1);
    // Back-to-back 1010 then 0110.
    add(1, 1, 1, 0, 4'b0000, 1, 2'd1, 4'b0001, 0, 0, 1);
    add(1, 1, 0, 1, 4'b0010, 1, 2'd2, 4'b0001, 0, 0, 1);
    add(1, 1, 0, 0, 4'b0000, 1, 2'd3, 4'b0001, 0, 0, 1);
    add(1, 1, 0, 1, 4'b1000, 1, 2'd0, 4'b1010, 1, 0, 1);
    add(1, 1, 1, 0, 4'b0000, 1, 2'd1, 4'b1010, 0, 0, 1);
    add(1, 1, 0, 1, 4'b0010, 1, 2'd2, 4'b1010, 0, 0, 1);
    add(1, 1, 0, 1, 4'b0100, 1, 2'd3, 4'b1010, 0, 0, 1);
    add(1, 1, 0, 0, 4'b0000, 1, 2'd0, 4'b0110, 1, 0, 1);
    // Frame 1011 with gaps; sync without din_valid is ignored.
    add(1, 1, 1, 1, 4'b0001, 1, 2'd1, 4'b0110, 0, 0, 1);
    add(1, 0, 0, 0, 4'b0001, 0, 2'd1, 4'b0110, 0, 0, 1);
    add(1, 1, 0, 1, 4'b0010, 1, 2'd2, 4'b0110, 0, 0, 1);
    add(1, 0, 1, 1, 4'b0010, 0, 2'd2, 4'b0110, 0, 0, 1);
    add(1, 1, 0, 0, 4'b0000, 1, 2'd3, 4'b0110, 0, 0, 1);
    add(1, 0, 0, 0, 4'b0000, 0, 2'd3, 4'b0110, 0, 0, 1);
    add(1, 1, 0, 1, 4'b1000, 1, 2'd0, 4'b1011, 1, 0, 1);
    add(1, 0, 0, 0, 4'b1000, 0, 2'd0, 4'b1011, 0, 0, 1);
    // Early sync at beat 3, then a completed frame 1101.
    add(1, 1, 1, 1, 4'b0001, 1, 2'd1, 4'b1011, 0, 0, 1);
    add(1, 1, 0, 0, 4'b0000, 1, 2'd2, 4'b1011, 0, 0, 1);
    add(1, 1, 1, 1, 4'b0001, 1, 2'd1, 4'b1011, 0, 1, 1);
    add(1, 1, 0, 0, 4'b0000, 1, 2'd2, 4'b1011, 0, 0, 1);
    add(1, 1, 0, 1, 4'b0100, 1, 2'd3, 4'b1011, 0, 0, 1);
    add(1, 1, 0, 1, 4'b1000, 1, 2'd0, 4'b1101, 1, 0, 1);
    // Missing sync at ch0: error, unlock, ignore until next sync.
    add(1, 1, 0, 1, 4'b1000, 0, 2'd0, 4'b1101, 0, 1, 0);
    add(1, 1, 0, 1, 4'b1000, 0, 2'd0, 4'b1101, 0, 0, 0);
    add(1, 1, 1, 0, 4'b0000, 1, 2'd1, 4'b1101, 0, 0, 1);
    add(1, 1, 0, 1, 4'b0010, 1, 2'd2, 4'b1101, 0, 0, 1);
    // Reset mid-frame (ch=2), then HUNT behaviour.
    add(0, 1, 0, 1, 4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0);
    add(1, 1, 0, 1, 4'b0000, 0, 2'd0, 4'b0000, 0, 0, 0);
    add(1, 1, 1, 1, 4'b0001, 1, 2'd1, 4'b0000, 0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].dv, vecs[i].sync, vecs[i].din);
      n_vec++;
      check("y",          i, 32'(bus.y),          32'(vecs[i].y));
      check("y_valid",    i, 32'(bus.y_valid),    32'(vecs[i].yv));
      check("ch_idx",     i, 32'(bus.ch_idx),     32'(vecs[i].ch));
      check("dout",       i, 32'(bus.dout),       32'(vecs[i].dout));
      check("dout_valid", i, 32'(bus.dout_valid), 32'(vecs[i].dov));
      check("frame_err",  i, 32'(bus.frame_err),  32'(vecs[i].fe));
      check("locked",     i, 32'(bus.locked),     32'(vecs[i].lk));
    end

    // Full-rate stream: dout_valid exactly on every 4th beat, no bubble.
    frames[0] = 4'b1100;
    frames[1] = 4'b0011;
    frames[2] = 4'b1001;
    step(0, 0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        step(1, 1, (b == 0), frames[f][b]);
        n_vec++;
        check("stream_dout_valid", 100 + f * 4 + b, 32'(bus.dout_valid), 32'(b == 3));
        check("stream_ch_idx", 100 + f * 4 + b, 32'(bus.ch_idx), 32'((b + 1) % 4));
        check("stream_frame_err", 100 + f * 4 + b, 32'(bus.frame_err), 32'(0));
        if (b == 3) begin
          check("stream_dout", 100 + f * 4 + b, 32'(bus.dout), 32'(frames[f]));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_tdm_sync.md
Name: demux_tdm_sync

Overview:
- Receive-side counterpart of the 4:1 selector mux.
- Takes the 1-bit time-multiplexed stream a mux produces when its select is stepped 00→01→10→11. Frames are marked by a sync strobe.
- Demultiplexes each beat to its channel, then reassembles the channels into a parallel word.
- Sits after the mux/serial link; feeds parallel consumers with a word-valid strobe and a frame-error flag.

Parameters:
- N_CH, 4, number of time slots (channels) per frame; must be ≥2.
- SEL_W, 2, width of channel index, = clog2(N_CH).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- din  in  1  serial TDM data bit.
- din_valid  in  1  din carries a beat this cycle.
- sync  in  1  qualified by din_valid; marks this beat as channel 0.
- y  out  N_CH  registered one-hot demux output; bit[ch] = din of the last accepted beat, others 0.
- y_valid  out  1  one-cycle pulse: y holds a new beat.
- ch_idx  out  SEL_W  channel index the next accepted beat will land in.
- dout  out  N_CH  reassembled frame; bit i = channel i.
- dout_valid  out  1  one-cycle pulse: dout updated.
- frame_err  out  1  one-cycle pulse: sync framing violation.
- locked  out  1  high in LOCK state.

Behaviour:
- Reset (rst_n=0 at rising clk): state=HUNT, ch=0, slot buffer=0. All outputs 0: y, y_valid, dout, dout_valid, frame_err, locked, ch_idx. Reset overrides any in-progress frame; the partial frame is discarded.
- Beat = rising clk with din_valid=1. Cycles with din_valid=0 change nothing except clearing the pulse outputs.
- Pulse outputs (y_valid, dout_valid, frame_err) default to 0 each cycle.
- HUNT state:
  - Beat with sync=0: ignored; no y_valid.
  - Beat with sync=1: slot[0]<=din, y<=din at bit 0, y_valid<=1, ch<=1, go LOCK.
- LOCK state, beat:
  - sync=1 and ch=0: normal frame start. Store slot[0], ch<=1.
  - sync=0 and 0<ch<N_CH-1: store slot[ch], ch<=ch+1.
  - ch=N_CH-1 and sync=0: dout<={din, slot[N_CH-2:0]}, dout_valid<=1, ch<=0.
  - sync=1 and ch≠0 (early sync): frame_err<=1. Partial frame dropped (no dout_valid). The beat is treated as a new channel 0: slot[0]<=din, ch<=1. Stay in LOCK.
  - sync=0 and ch=0 (missing sync): frame_err<=1, go HUNT, ch<=0. Beat not demuxed (y_valid=0).
  - Every demuxed beat: y<=din shifted to bit ch, y_valid<=1.
- Latency:
  - y/y_valid: 1 cycle after the beat.
  - dout/dout_valid: 1 cycle after the channel N_CH-1 beat.
  - dout holds its value until the next complete frame.
- Back-to-back frames at full rate (din_valid constantly 1) give one dout_valid every N_CH cycles with no bubble.
- ch_idx = ch register. locked = (state==LOCK).
- Width rules: ch is SEL_W bits and wraps via explicit compare to N_CH-1, not modulo overflow. This keeps it correct for non-power-of-2 N_CH.

Decomposition:
- Package demux_pkg:
  - state enum {HUNT, LOCK}
  - localparam defaults N_CH=4, SEL_W=2
- Sub-module demux_onehot: combinational N_CH-way decoder (din, ch) → one-hot y_next. Reused from the demux family; top registers its output.
- Frame FSM, slot buffer, and counter live in the top.

Test Plan:
- Reset: drive rst_n=0 for 2 clks with din_valid=1, sync=1, din=1 → all outputs 0, locked=0; release → first sync beat sets locked=1 next cycle.
- Nominal frame mirroring mux stimulus D=4'b0001: beats din=1(sync),0,0,0 → y sequence 0001,0000,0000,0000 with y_valid each cycle; dout=4'b0001, dout_valid pulse 1 cycle after 4th beat.
- Back-to-back frames 4'b1010 then 4'b0110, din_valid held 1 → dout_valid at cycles 5 and 9 only, dout=1010 then 0110.
- Gaps: same 4'b1011 frame with din_valid=0 inserted between every beat → dout=1011, ch_idx unchanged during gaps, no spurious pulses.
- Early sync: sync at beat 3 of a frame → frame_err pulse, no dout_valid, that beat becomes ch0; the next 3 beats complete a valid frame → dout_valid.
- Missing sync at ch0 while locked → frame_err pulse, locked=0, beats ignored until next sync; also rst_n=0 mid-frame (ch=2) → ch_idx=0, HUNT, no dout_valid.
